imem_fetch_ctrl: RTL and testbench

Sequencer and arbiter in front of the byte-wide (8-bit, 256-entry) instruction memory. It turns a core fetch request into four byte reads and assembles a little-endian 32-bit instruction. It also shares the single memory port with a byte-serial program loader. It sits between the single-cycle core's PC/fetch stage and a synchronous-read byte RAM, and replaces direct combinational 4-byte indexing.

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_byte_ram.sv | 49 ++++
 rtl/imem_fetch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch path.
//   - fetch_state_t : controller states (IDLE, ISSUE, DRAIN, RESP)
//   - IMEM_ADDR_W    : default byte-address width of the instruction memory
//   - IMEM_MEM_BYTES : default memory size in bytes (2**IMEM_ADDR_W)
//   - IMEM_NOP_INSTR : instruction handed to the core when a fetch faults
//   - laneLsb()      : bit offset of a little-endian byte lane in a word
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int          IMEM_ADDR_W    = 8;
    localparam int          IMEM_MEM_BYTES = 256;
    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } fetch_state_t;

    // Byte lane k of a little-endian word lives at bits [8k+7:8k], so the
    // lane number shifted up by three gives the least significant bit.
    function automatic logic [4:0] laneLsb(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// ---------------------------------------------------------------------------
// imem_byte_ram
// Byte-wide single-port instruction RAM, 2**ADDR_W entries of 8 bits.
// Reads and writes are both synchronous: a read issued with i_en=1 and
// i_we=0 returns its byte on o_rdata one cycle later. The array has no
// reset, so contents survive a controller reset; the program image is
// written in through the port by the byte-serial loader.
//
// Ports:
//   i_clk    in   1       rising-edge clock
//   i_en     in   1       access strobe
//   i_we     in   1       write enable (qualified by i_en)
//   i_addr   in   ADDR_W  byte address
//   i_wdata  in   8       write data
//   o_rdata  out  8       read data, registered
// ---------------------------------------------------------------------------
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_rdata;

    // One access per cycle. A write updates the array and leaves the read
    // register alone; a read loads the read register so the byte appears
    // on the following cycle, which is the latency the fetch sequencer
    // is built around.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer and memory-port arbiter in front of the byte-wide
// instruction RAM. A core fetch is turned into four byte reads (base+0 ..
// base+3) whose results are assembled little-endian into a 32-bit
// instruction. The same memory port is shared with a byte-serial program
// loader, which is only served while the sequencer is idle and wins over
// a fetch requested in the same cycle.
//
// Fetch timeline (E0 = edge that accepts the request):
//   good address : ISSUE k=0..3 after E0..E3, DRAIN after E4, RESP after E5
//   bad address  : RESP straight after E0 with NOP_INSTR and fetch_err=1
//
// Build option:
//   IMEM_WR_PROTECT_EN - when defined, the first fetch grant after reset
//   sets a sticky lock that refuses all further loader writes until reset.
//
// Ports:
//   i_clk          in   1       rising-edge clock
//   i_rst_n        in   1       asynchronous active-low reset
//   i_fetch_req    in   1       core fetch request, held until handshake
//   i_fetch_addr   in   32      fetch byte address, sampled at grant
//   o_fetch_gnt    out  1       request accepted this cycle
//   o_fetch_valid  out  1       response valid
//   i_fetch_ready  in   1       core takes the response
//   o_fetch_instr  out  32      assembled instruction {b3,b2,b1,b0}
//   o_fetch_err    out  1       misaligned / out-of-range fetch
//   i_ld_valid     in   1       loader byte write request
//   i_ld_addr      in   ADDR_W  loader byte address
//   i_ld_data      in   8       loader byte
//   o_ld_ready     out  1       loader write accepted this cycle
//   o_mem_en       out  1       memory access strobe
//   o_mem_we       out  1       memory write enable
//   o_mem_addr     out  ADDR_W  memory byte address
//   o_mem_wdata    out  8       memory write data
//   i_mem_rdata    in   8       memory read data (one cycle after read)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter int          MEM_BYTES = IMEM_MEM_BYTES,
    parameter logic [31:0] NOP_INSTR = IMEM_NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_addr,
    output logic              o_fetch_gnt,
    output logic              o_fetch_valid,
    input  logic              i_fetch_ready,
    output logic [31:0]       o_fetch_instr,
    output logic              o_fetch_err,
    input  logic              i_ld_valid,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [7:0]        i_ld_data,
    output logic              o_ld_ready,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    fetch_state_t      r_state;
    fetch_state_t      w_stateNext;

    logic [1:0]        r_byteCnt;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_instr;
    logic              r_err;
    logic              r_rdPending;
    logic [1:0]        r_rdLane;

    logic              w_lock;
    logic              w_addrBad;
    logic              w_accept;
    logic              w_issueRead;
    logic              w_ldReady;
    logic              w_memEn;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [7:0]        w_memWdata;

`ifdef IMEM_WR_PROTECT_EN
    logic r_lock;

    // Sticky write-protect: once the core has been granted its first fetch
    // the program is considered running, and only a reset reopens the
    // loader path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= 1'b1;
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    // A fetch address is rejected when it is not word aligned or does not
    // fall inside the memory. The comparison is done on the full 32-bit
    // address so high bits cannot alias back into range.
    assign w_addrBad = (i_fetch_addr[1:0] != 2'b00) ||
                       (i_fetch_addr >= 32'(MEM_BYTES));

    // State register for the sequencer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and memory-port arbitration. In IDLE the loader is looked
    // at first, so a write and a fetch arriving together are served write
    // first and the fetch is granted on the following cycle. When the
    // write-protect lock refuses the loader, a pending fetch still goes
    // through so a stuck loader cannot starve the core. The combinational
    // strobes are also gated by reset so nothing reaches the RAM or the
    // handshakes while rst_n is low.
    always_comb begin
        w_stateNext = r_state;
        w_ldReady   = 1'b0;
        w_accept    = 1'b0;
        w_issueRead = 1'b0;
        w_memEn     = 1'b0;
        w_memWe     = 1'b0;
        w_memAddr   = '0;
        w_memWdata  = '0;

        case (r_state)
            IDLE: begin
                if (i_rst_n && i_ld_valid && !w_lock) begin
                    w_ldReady  = 1'b1;
                    w_memEn    = 1'b1;
                    w_memWe    = 1'b1;
                    w_memAddr  = i_ld_addr;
                    w_memWdata = i_ld_data;
                end else if (i_rst_n && i_fetch_req) begin
                    w_accept    = 1'b1;
                    w_stateNext = w_addrBad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                w_issueRead = 1'b1;
                w_memEn     = 1'b1;
                w_memAddr   = r_base + ADDR_W'(r_byteCnt);
                if (r_byteCnt == 2'd3) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                w_stateNext = RESP;
            end
            RESP: begin
                if (i_fetch_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Fetch datapath. The base address and error flag are captured at
    // grant, so the core may change fetch_addr afterwards. Each read issued
    // in ISSUE is remembered together with its lane for one cycle, because
    // the RAM presents that byte a cycle later; the last byte is therefore
    // caught while the sequencer sits in DRAIN. A bad address loads the
    // NOP pattern directly and never touches the RAM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byteCnt   <= 2'd0;
            r_base      <= '0;
            r_instr     <= 32'd0;
            r_err       <= 1'b0;
            r_rdPending <= 1'b0;
            r_rdLane    <= 2'd0;
        end else begin
            r_rdPending <= w_issueRead;
            r_rdLane    <= r_byteCnt;

            if (w_accept) begin
                r_base    <= i_fetch_addr[ADDR_W-1:0];
                r_byteCnt <= 2'd0;
                r_err     <= w_addrBad;
                if (w_addrBad) begin
                    r_instr <= NOP_INSTR;
                end
            end else if (w_issueRead) begin
                r_byteCnt <= r_byteCnt + 2'd1;
            end

            if (r_rdPending) begin
                r_instr[laneLsb(r_rdLane) +: 8] <= i_mem_rdata;
            end
        end
    end

    assign o_fetch_gnt   = w_accept;
    assign o_fetch_valid = (r_state == RESP);
    assign o_fetch_instr = r_instr;
    assign o_fetch_err   = r_err;
    assign o_ld_ready    = w_ldReady;
    assign o_mem_en      = w_memEn;
    assign o_mem_we      = w_memWe;
    assign o_mem_addr    = w_memAddr;
    assign o_mem_wdata   = w_memWdata;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Bench for imem_fetch_ctrl wired to an imem_byte_ram. The bench keeps its
// own byte array of what the program memory should hold; expected fetch
// words are built from that array by little-endian concatenation, bad
// addresses map to the NOP word with the error flag set. Inputs are driven
// just after the falling edge and outputs are sampled 1 ns later.
// With IMEM_WR_PROTECT_EN defined, the bench expects loader writes to be
// refused after the first grant following a reset.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstN;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic        fetchGnt;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchInstr;
    logic        fetchErr;
    logic        ldValid;
    logic [7:0]  ldAddr;
    logic [7:0]  ldData;
    logic        ldReady;
    logic        memEn;
    logic        memWe;
    logic [7:0]  memAddr;
    logic [7:0]  memWdata;
    logic [7:0]  memRdata;

    int          checks;
    int          errors;
    logic        locked;
    logic [7:0]  memModel [256];

    imem_fetch_ctrl #(
        .ADDR_W    (8),
        .MEM_BYTES (256),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_fetch_req   (fetchReq),
        .i_fetch_addr  (fetchAddr),
        .o_fetch_gnt   (fetchGnt),
        .o_fetch_valid (fetchValid),
        .i_fetch_ready (fetchReady),
        .o_fetch_instr (fetchInstr),
        .o_fetch_err   (fetchErr),
        .i_ld_valid    (ldValid),
        .i_ld_addr     (ldAddr),
        .i_ld_data     (ldData),
        .o_ld_ready    (ldReady),
        .o_mem_en      (memEn),
        .o_mem_we      (memWe),
        .o_mem_addr    (memAddr),
        .o_mem_wdata   (memWdata),
        .i_mem_rdata   (memRdata)
    );

    imem_byte_ram #(
        .ADDR_W (8)
    ) uRam (
        .i_clk   (clk),
        .i_en    (memEn),
        .i_we    (memWe),
        .i_addr  (memAddr),
        .i_wdata (memWdata),
        .o_rdata (memRdata)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference word for a fetch, taken straight from the address rules:
    // misaligned or beyond the 256-byte memory gives the NOP word,
    // otherwise the four bytes starting at the address, lowest byte first.
    function automatic logic [31:0] modelInstr(input logic [31:0] a);
        int b;
        if ((a[1:0] != 2'b00) || (a >= 32'd256)) begin
            return NOP;
        end
        b = int'(a);
        return {memModel[b+3], memModel[b+2], memModel[b+1], memModel[b]};
    endfunction

    function automatic logic modelBad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd256);
    endfunction

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs after the falling edge, then let
    // combinational outputs settle before the caller samples.
    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic ready, input logic ldv,
                                 input logic [7:0] lda, input logic [7:0] ldd);
        @(negedge clk);
        fetchReq   = req;
        fetchAddr  = addr;
        fetchReady = ready;
        ldValid    = ldv;
        ldAddr     = lda;
        ldData     = ldd;
        #1;
    endtask

    // Single loader byte write; refused once the write-protect lock is set.
    task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, a, d);
        checkOutput("ld_ready", {31'd0, ldReady}, {31'd0, !locked});
        if (!locked) begin
            checkOutput("ld_mem_port", {14'd0, memEn, memWe, memAddr, memWdata},
                        {14'd0, 1'b1, 1'b1, a, d});
            memModel[a] = d;
        end
    endtask

    // Raise a fetch request and wait, bounded, for the grant pulse.
    task automatic startFetch(input logic [31:0] addr);
        int n;
        n = 0;
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 8'd0, 8'd0);
        while (!fetchGnt && n < 10) begin
            applyStimulus(1'b1, addr, 1'b0, 1'b0, 8'd0, 8'd0);
            n++;
        end
        checkOutput("fetch_gnt", {31'd0, fetchGnt}, 32'd1);
`ifdef IMEM_WR_PROTECT_EN
        if (fetchGnt) begin
            locked = 1'b1;
        end
`endif
    endtask

    // Follow a granted fetch to completion. The address lines are scrambled
    // after the grant; the loader may be held active the whole time; the
    // core withholds ready for 1+hold response cycles.
    task automatic finishFetch(input logic [31:0] addr, input int hold,
                               input logic ldDuring, input logic [7:0] ldA,
                               input logic [7:0] ldD);
        logic [31:0] expInstr;
        logic        bad;
        logic        memSeen;
        logic        ldSeen;
        logic        gntSeen;
        int          n;
        expInstr = modelInstr(addr);
        bad      = modelBad(addr);
        memSeen  = 1'b0;
        ldSeen   = 1'b0;
        gntSeen  = 1'b0;
        n        = 0;
        do begin
            applyStimulus(1'b1, $urandom, 1'b0, ldDuring, ldA, ldD);
            n++;
            if (memEn) memSeen = 1'b1;
            if (ldReady) ldSeen = 1'b1;
            if (fetchGnt) gntSeen = 1'b1;
        end while (!fetchValid && n < 20);
        checkOutput("valid_latency", n, bad ? 32'd1 : 32'd6);
        checkOutput("mem_en_during_fetch", {31'd0, memSeen}, {31'd0, !bad});
        checkOutput("resp_instr", fetchInstr, expInstr);
        checkOutput("resp_err", {31'd0, fetchErr}, {31'd0, bad});
        for (int h = 0; h < hold; h++) begin
            applyStimulus(1'b1, $urandom, 1'b0, ldDuring, ldA, ldD);
            checkOutput("hold_valid_instr", {fetchValid, fetchInstr[30:0]},
                        {1'b1, expInstr[30:0]});
            if (ldReady) ldSeen = 1'b1;
        end
        applyStimulus(1'b1, $urandom, 1'b1, ldDuring, ldA, ldD);
        checkOutput("handshake_valid", {31'd0, fetchValid}, 32'd1);
        if (ldReady) ldSeen = 1'b1;
        checkOutput("busy_no_ld_or_gnt", {30'd0, ldSeen, gntSeen}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, ldDuring, ldA, ldD);
        checkOutput("idle_after_handshake", {31'd0, fetchValid}, 32'd0);
        if (ldDuring) begin
            checkOutput("ld_first_idle", {31'd0, ldReady}, {31'd0, !locked});
            if (!locked) memModel[ldA] = ldD;
        end
    endtask

    task automatic doFetch(input logic [31:0] addr, input int hold,
                           input logic ldDuring, input logic [7:0] ldA,
                           input logic [7:0] ldD);
        startFetch(addr);
        finishFetch(addr, hold, ldDuring, ldA, ldD);
    endtask

    // Directed sequence followed by randomized traffic.
    initial begin
        logic [7:0]  preBytes [4];
        logic [31:0] a;
        int          sel;
        checks     = 0;
        errors     = 0;
        locked     = 1'b0;
        rstN       = 1'b0;
        fetchReq   = 1'b0;
        fetchAddr  = 32'd0;
        fetchReady = 1'b0;
        ldValid    = 1'b0;
        ldAddr     = 8'd0;
        ldData     = 8'd0;
        preBytes   = '{8'h13, 8'h05, 8'h00, 8'h04};

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    {27'd0, fetchGnt, fetchValid, fetchErr, memEn, memWe},
                    32'd0);
        checkOutput("reset_instr", fetchInstr, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] preload memory through the loader");
        for (int i = 0; i < 256; i++) begin
            doWrite(i[7:0], (i < 4) ? preBytes[i] : 8'($urandom));
        end

        $display("[TB] aligned fetch at 0x00");
        doFetch(32'h0, 0, 1'b0, 8'd0, 8'd0);
        checkOutput("word_at_0", fetchInstr, 32'h0400_0513);

        $display("[TB] error fetches");
        doFetch(32'h2, 0, 1'b0, 8'd0, 8'd0);
        doFetch(32'h100, 0, 1'b0, 8'd0, 8'd0);

        $display("[TB] loader and fetch in the same cycle");
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 8'h10, 8'hAB);
        checkOutput("ld_vs_fetch", {30'd0, ldReady, fetchGnt},
                    {30'd0, !locked, locked});
        if (!locked) begin
            memModel[8'h10] = 8'hAB;
            startFetch(32'h10);
        end
        finishFetch(32'h10, 0, 1'b0, 8'd0, 8'd0);

        $display("[TB] loader held during a fetch, response held off");
        doFetch(32'h20, 2, 1'b1, 8'h21, 8'h5C);
        doFetch(32'h20, 0, 1'b0, 8'd0, 8'd0);

        $display("[TB] reset in the middle of ISSUE");
        startFetch(32'h4);
        repeat (3) applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 8'd0, 8'd0);
        checkOutput("issue_k2_addr", {23'd0, memEn, memAddr}, {23'd0, 1'b1, 8'h06});
        rstN     = 1'b0;
        fetchReq = 1'b0;
        #1;
        checkOutput("midfetch_reset_outputs",
                    {27'd0, fetchGnt, fetchValid, fetchErr, memEn, memWe},
                    32'd0);
        checkOutput("midfetch_reset_instr", fetchInstr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN   = 1'b1;
        locked = 1'b0;
        doWrite(8'h05, 8'h77);
        doFetch(32'h4, 0, 1'b0, 8'd0, 8'd0);
        doWrite(8'h06, 8'h99);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        doFetch(32'h4, 1, 1'b0, 8'd0, 8'd0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                doWrite(8'($urandom), 8'($urandom));
                applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0);
            end else begin
                if (sel < 7) begin
                    a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                end else if (sel < 9) begin
                    a = {24'd0, 8'($urandom_range(0, 255))} | 32'd1;
                end else begin
                    a = $urandom | 32'h100;
                end
                doFetch(a, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                        8'($urandom), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
